// File: rtl/sprite_attr_table_pkg.sv
// Shared types and constants for the double-buffered sprite attribute table.
package sprite_attr_table_pkg;

    localparam int unsigned ID_W    = 5;
    localparam int unsigned X_W     = 9;
    localparam int unsigned Y_W     = 10;
    localparam int unsigned ENTRY_W = ID_W + X_W + Y_W;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COORD_W = 10;

    localparam logic [ADDR_W-1:0] CTRL_ADDR   = 5'd31;
    localparam logic [ID_W-1:0]   ID_DISABLED = '0;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [X_W-1:0]  x;
        logic [Y_W-1:0]  y;
    } sprite_entry_t;

    localparam sprite_entry_t EMPTY_ENTRY = '{id: ID_DISABLED, x: '0, y: '0};

endpackage

// File: rtl/sprite_attr_table_if.sv
// Avalon-MM slave bus carrying software access to the shadow table and CTRL.
interface sprite_attr_table_if;
    import sprite_attr_table_pkg::*;

    logic              chipselect;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output chipselect,
        output write,
        output read,
        output address,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  write,
        input  read,
        input  address,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/sprite_commit_detect.sv
// Raises a single-cycle commit strobe at the start of the commit line, at most once per frame.
module sprite_commit_detect
    import sprite_attr_table_pkg::*;
#(
    parameter int unsigned COMMIT_LINE = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pending,
    input  logic [COORD_W-1:0] vcount,
    input  logic [COORD_W-1:0] hcount,
    output logic               commit
);

    logic armed_q;
    logic armed_d;
    logic at_line;

    // Disarm on commit; re-arm only once the beam has left the commit line.
    always_comb begin
        at_line = (vcount == COORD_W'(COMMIT_LINE));
        commit  = pending && armed_q && at_line && (hcount == '0);
        armed_d = armed_q;
        if (commit) begin
            armed_d = 1'b0;
        end else if (!at_line) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed_q <= 1'b1;
        end else begin
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/sprite_attr_table.sv
// Sprite descriptor table: software writes a shadow copy, which is copied to the
// display-facing active copy in a single cycle at the start of vblank.
module sprite_attr_table
    import sprite_attr_table_pkg::*;
#(
    parameter int unsigned NUM_SPRITES = 20,
    parameter int unsigned COMMIT_LINE = 480
) (
    input  logic                clk,
    input  logic                reset,
    sprite_attr_table_if.slave  bus,
    input  logic [COORD_W-1:0]  VGA_HCOUNT,
    input  logic [COORD_W-1:0]  VGA_VCOUNT,
    input  logic [ADDR_W-1:0]   rd_idx,
    output logic [ENTRY_W-1:0]  rd_data,
    output logic [ENTRY_W-1:0]  sprite1,
    output logic                frame_tick
);

    localparam int unsigned IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    sprite_entry_t     shadow_q [NUM_SPRITES];
    sprite_entry_t     active_q [NUM_SPRITES];
    logic              pending_q;
    logic              pending_d;
    logic [DATA_W-1:0] readdata_q;
    logic [DATA_W-1:0] rd_word;
    sprite_entry_t     rd_data_q;
    sprite_entry_t     act_word;
    logic              frame_tick_q;
    logic              commit;

    logic bus_wr;
    logic bus_rd;
    logic addr_is_entry;
    logic addr_is_ctrl;
    logic idx_is_entry;
    logic shadow_wr;
    logic ctrl_wr;

    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[DATA_W-1:ENTRY_W];

    always_comb begin
        bus_wr        = bus.chipselect && bus.write;
        bus_rd        = bus.chipselect && bus.read;
        addr_is_entry = (32'(bus.address) < NUM_SPRITES);
        addr_is_ctrl  = (bus.address == CTRL_ADDR);
        idx_is_entry  = (32'(rd_idx) < NUM_SPRITES);
        shadow_wr     = bus_wr && addr_is_entry;
        ctrl_wr       = bus_wr && addr_is_ctrl;
    end

    sprite_commit_detect #(
        .COMMIT_LINE (COMMIT_LINE)
    ) u_commit_detect (
        .clk     (clk),
        .reset   (reset),
        .pending (pending_q),
        .vcount  (VGA_VCOUNT),
        .hcount  (VGA_HCOUNT),
        .commit  (commit)
    );

    // A CTRL write in the commit cycle overrides the commit's clear.
    always_comb begin
        pending_d = pending_q;
        if (commit) begin
            pending_d = 1'b0;
        end
        if (ctrl_wr) begin
            pending_d = bus.writedata[0];
        end
    end

    always_comb begin
        rd_word = '0;
        if (addr_is_entry) begin
            rd_word = {{(DATA_W-ENTRY_W){1'b0}}, shadow_q[bus.address[IDX_W-1:0]]};
        end else if (addr_is_ctrl) begin
            rd_word = {{(DATA_W-1){1'b0}}, pending_q};
        end
    end

    always_comb begin
        act_word = EMPTY_ENTRY;
        if (idx_is_entry) begin
            act_word = active_q[rd_idx[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_q[i] <= EMPTY_ENTRY;
            end
        end else if (shadow_wr) begin
            shadow_q[bus.address[IDX_W-1:0]] <= sprite_entry_t'(bus.writedata[ENTRY_W-1:0]);
        end
    end

    // Nonblocking copy: a same-cycle shadow write lands after active takes the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                active_q[i] <= EMPTY_ENTRY;
            end
        end else if (commit) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q    <= 1'b0;
            readdata_q   <= '0;
            rd_data_q    <= EMPTY_ENTRY;
            frame_tick_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            rd_data_q    <= act_word;
            frame_tick_q <= commit;
            if (bus_rd) begin
                readdata_q <= rd_word;
            end
        end
    end

    assign bus.readdata = readdata_q;
    assign rd_data      = rd_data_q;
    assign sprite1      = active_q[0];
    assign frame_tick   = frame_tick_q;

endmodule
